// File: rtl/adc_readout_module.sv
// adc_readout_module: reads N 128-bit RAM words and streams them out as four 32-bit beats each
// Define ADC_READOUT_HEADER_EN to prepend a {16'hADC0, length} header beat to every transfer.
module adc_readout_module #(
    parameter int RAM_LATENCY = 2,
    parameter int BUF_DEPTH   = 4
) (
    input  logic         iClk,
    input  logic         iRstN,
    input  logic         iReadStart,
    input  logic         iAbort,
    input  logic [15:0]  iRecLength,
    output logic         oRDEN,
    output logic [14:0]  oRAddr,
    input  logic [127:0] iRAMData,
    output logic [31:0]  oData,
    output logic         oValid,
    input  logic         iReady,
    output logic         oLast,
    output logic         oBusy,
    output logic         oReadDone
);
    localparam int PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(BUF_DEPTH + RAM_LATENCY + 3);
`ifdef ADC_READOUT_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nxt;
    logic [14:0] n_in, len, iss_cnt, ld_cnt;
    logic [RAM_LATENCY:0] pipe;
    logic [127:0] mem [BUF_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CNTW-1:0] cnt;
    logic [127:0] ser_word;
    logic [1:0] beat;
    logic ser_last;
    logic [CW-1:0] outstanding;
    logic start, hdr_load, ret_vld, fire, ser_free, fifo_pop, direct, fifo_push, do_issue;

    assign n_in      = (iRecLength > 16'd16384) ? 15'd16384 : iRecLength[14:0];
    assign start     = state == IDLE && iReadStart && !iAbort;
    assign hdr_load  = start && HDR;
    assign ret_vld   = pipe[RAM_LATENCY];
    assign fire      = oValid && iReady;
    assign ser_free  = !oValid || (iReady && beat == 2'd3);
    assign fifo_pop  = ser_free && cnt != '0 && !hdr_load;
    assign direct    = ser_free && cnt == '0 && ret_vld && !hdr_load;
    assign fifo_push = ret_vld && !direct;
    assign do_issue  = !iAbort && ((start && n_in != '0) ||
                       (state == READ && iss_cnt != len && outstanding < CW'(BUF_DEPTH)));
    assign oRDEN     = pipe[0];
    assign oData     = ser_word[{beat, 5'd0} +: 32];
    assign oLast     = oValid && beat == 2'd3 && ser_last;

    // credit count: words buffered, being serialised, or still inside the RAM pipeline
    always_comb begin
        outstanding = CW'(cnt) + CW'(oValid);
        for (int i = 0; i <= RAM_LATENCY; i++) outstanding = outstanding + CW'(pipe[i]);
    end

    // state register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? (n_in != '0 ? READ : (HDR ? DRAIN : DONE)) : IDLE;
            READ:    state_nxt = iss_cnt == len ? DRAIN : READ;
            DRAIN:   state_nxt = (fire && oLast) ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
        if (iAbort) state_nxt = IDLE;
    end

    // state-decoded outputs
    always_comb begin
        oBusy     = state == READ || state == DRAIN;
        oReadDone = state == DONE;
    end

    // read issue: address counter, latched length and in-flight tracking
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            pipe    <= '0;
            oRAddr  <= '0;
            iss_cnt <= '0;
            len     <= '0;
        end else begin
            pipe <= iAbort ? '0 : {pipe[RAM_LATENCY-1:0], do_issue};
            if (start) len <= n_in;
            if (do_issue) begin
                oRAddr  <= iss_cnt;
                iss_cnt <= iss_cnt + 15'd1;
            end else if (iAbort || state == DONE) begin
                iss_cnt <= '0;
            end
        end
    end

    // return buffer pointers; returns bypass it when the serialiser is free
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN || !iRstN) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (iAbort) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (fifo_push) wp <= (wp == PW'(BUF_DEPTH - 1)) ? '0 : wp + 1'b1;
            if (fifo_pop) rp <= (rp == PW'(BUF_DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CNTW'(fifo_push) - CNTW'(fifo_pop);
        end
    end

    // return buffer storage
    always_ff @(posedge iClk) begin
        if (fifo_push) mem[wp] <= iRAMData;
    end

    // serialiser: header sits in the top lane at beat 3 so one slice mux serves both
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oValid   <= 1'b0;
            ser_word <= '0;
            beat     <= '0;
            ser_last <= 1'b0;
            ld_cnt   <= '0;
        end else if (iAbort) begin
            oValid <= 1'b0;
            ld_cnt <= '0;
        end else if (hdr_load) begin
            oValid   <= 1'b1;
            ser_word <= {16'hADC0, iRecLength, 96'd0};
            beat     <= 2'd3;
            ser_last <= n_in == '0;
        end else if (state == DONE) begin
            ld_cnt <= '0;
        end else if (ser_free) begin
            oValid <= fifo_pop || direct;
            beat   <= '0;
            if (fifo_pop || direct) begin
                ser_word <= fifo_pop ? mem[rp] : iRAMData;
                ser_last <= ld_cnt == len - 15'd1;
                ld_cnt   <= ld_cnt + 15'd1;
            end
        end else if (fire) begin
            beat <= beat + 2'd1;
        end
    end
endmodule
